nco_slot_scheduler: RTL

NCO_SLOT_SCHEDULER -- requirements
Module: nco_slot_scheduler

---
 rtl/nco_slot_scheduler_if.sv | 35 +++
 rtl/nco_slot_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nco_slot_scheduler_if.sv
// Request/strobe bundle between an NCO slot scheduler and its requester.
// Master = requester / NCO datapath, slave = scheduler.
interface nco_slot_scheduler_if #(
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
);
  logic               en;
  logic               zero_req;
  logic [V_WIDTH-1:0] zero_vx;
  logic               zero_ack;
  logic               pitch_req;
  logic [V_WIDTH-1:0] pitch_vx;
  logic [O_WIDTH-1:0] pitch_ox;
  logic [23:0]        pitch_in;
  logic               pitch_rdy;
  logic [V_WIDTH-1:0] vx;
  logic [O_WIDTH-1:0] ox;
  logic               slot_stb;
  logic               frame_stb;
  logic               accum_zero;
  logic               pitch_we;
  logic [23:0]        pitch_out;

  modport master (
    output en, zero_req, zero_vx, pitch_req, pitch_vx, pitch_ox, pitch_in,
    input  zero_ack, pitch_rdy, vx, ox, slot_stb, frame_stb, accum_zero,
           pitch_we, pitch_out
  );

  modport slave (
    input  en, zero_req, zero_vx, pitch_req, pitch_vx, pitch_ox, pitch_in,
    output zero_ack, pitch_rdy, vx, ox, slot_stb, frame_stb, accum_zero,
           pitch_we, pitch_out
  );
endinterface

// File: rtl/nco_slot_scheduler.sv
// Time-slot scheduler for a multi-voice NCO bank. Walks (voice, oscillator)
// slots ox-inner / vx-outer, SLOT_CYC cycles each, and delivers queued
// phase-reset and pitch-update requests to the matching slots.
module nco_slot_scheduler #(
  parameter int VOICES   = 8,
  parameter int V_OSC    = 4,
  parameter int V_WIDTH  = 3,
  parameter int O_WIDTH  = 2,
  parameter int SLOT_CYC = 4
) (
  input  logic                 OSC_CLK,
  input  logic                 iRST,
  nco_slot_scheduler_if.slave  bus
);

  localparam int C_WIDTH = $clog2(SLOT_CYC);
  localparam logic [C_WIDTH-1:0] CNT_LAST = C_WIDTH'(SLOT_CYC - 1);
  localparam logic [V_WIDTH-1:0] VX_LAST  = V_WIDTH'(VOICES - 1);
  localparam logic [O_WIDTH-1:0] OX_LAST  = O_WIDTH'(V_OSC - 1);

  // slot position
  logic [C_WIDTH-1:0] cnt_reg, cnt_next;
  logic [V_WIDTH-1:0] vx_reg, vx_next;
  logic [O_WIDTH-1:0] ox_reg, ox_next;
  logic               slot_end;
  logic               slot_stb;

  // phase-reset bookkeeping
  logic [VOICES-1:0]  pend_reg, pend_next;
  logic [VOICES-1:0]  zero_hit, clr_hit;
  logic               pend_sel;
  logic               accum_zero_reg, accum_zero_next;
  logic               zero_ack_reg;

  // pitch holding register
  logic               valid_reg, valid_next;
  logic [V_WIDTH-1:0] hvx_reg;
  logic [O_WIDTH-1:0] hox_reg;
  logic [23:0]        hval_reg;
  logic [23:0]        pitch_out_reg;
  logic               pitch_capture;
  logic               pitch_fire;

  // Last enabled cycle of a slot: the edge that moves to the next slot.
  assign slot_end = bus.en && (cnt_reg == CNT_LAST);
  assign slot_stb = bus.en && (cnt_reg == '0);

  // Next slot position: count within the slot, then step ox, then vx.
  always_comb begin
    cnt_next = cnt_reg;
    vx_next  = vx_reg;
    ox_next  = ox_reg;
    if (bus.en) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        if (ox_reg == OX_LAST) begin
          ox_next = '0;
          vx_next = (vx_reg == VX_LAST) ? '0 : vx_reg + 1'b1;
        end else begin
          ox_next = ox_reg + 1'b1;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Slot counter and index registers.
  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      cnt_reg <= '0;
      vx_reg  <= '0;
      ox_reg  <= '0;
    end else begin
      cnt_reg <= cnt_next;
      vx_reg  <= vx_next;
      ox_reg  <= ox_next;
    end
  end

  // Per-voice pending bit: a new request beats the end-of-voice clear, so a
  // request landing on the clearing edge is served again next frame.
  // Out-of-range voice numbers match no bit and are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_pend
      assign zero_hit[gi]  = bus.zero_req && (bus.zero_vx == V_WIDTH'(gi));
      assign clr_hit[gi]   = slot_end && (ox_reg == OX_LAST) && accum_zero_reg &&
                             (vx_reg == V_WIDTH'(gi));
      assign pend_next[gi] = zero_hit[gi] | (pend_reg[gi] & ~clr_hit[gi]);
    end
  endgenerate

  // Pending bit of the voice owning the upcoming slot.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      if (vx_next == V_WIDTH'(i)) pend_sel = pend_reg[i];
    end
  end

  // accum_zero is sampled on the edge entering a slot so it is valid from
  // the slot's first cycle and stays constant for the whole slot.
  assign accum_zero_next = slot_end ? pend_sel : accum_zero_reg;

  // Pending bits, phase-reset command and request acknowledge.
  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      pend_reg       <= '0;
      accum_zero_reg <= 1'b0;
      zero_ack_reg   <= 1'b0;
    end else begin
      pend_reg       <= pend_next;
      accum_zero_reg <= accum_zero_next;
      zero_ack_reg   <= bus.zero_req;
    end
  end

  // A held pitch is written in the first cycle of its own slot; capture and
  // fire are mutually exclusive because one needs valid low, the other high.
  assign pitch_capture = bus.pitch_req && !valid_reg;
  assign pitch_fire    = slot_stb && valid_reg &&
                         (hvx_reg == vx_reg) && (hox_reg == ox_reg);

  always_comb begin
    valid_next = valid_reg;
    if (pitch_fire)         valid_next = 1'b0;
    else if (pitch_capture) valid_next = 1'b1;
  end

  // Pitch holding register and last-written pitch value.
  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      valid_reg     <= 1'b0;
      hvx_reg       <= '0;
      hox_reg       <= '0;
      hval_reg      <= '0;
      pitch_out_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      if (pitch_capture) begin
        hvx_reg  <= bus.pitch_vx;
        hox_reg  <= bus.pitch_ox;
        hval_reg <= bus.pitch_in;
      end
      if (pitch_fire) pitch_out_reg <= hval_reg;
    end
  end

  assign bus.vx         = vx_reg;
  assign bus.ox         = ox_reg;
  assign bus.slot_stb   = slot_stb;
  assign bus.frame_stb  = slot_stb && (vx_reg == '0) && (ox_reg == '0);
  assign bus.accum_zero = accum_zero_reg;
  assign bus.zero_ack   = zero_ack_reg;
  assign bus.pitch_rdy  = !valid_reg;
  assign bus.pitch_we   = pitch_fire;
  assign bus.pitch_out  = pitch_fire ? hval_reg : pitch_out_reg;

endmodule
